// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small FIFO; bytes arrive on a valid/ready handshake
// and are sent back-to-back with no idle gap while the FIFO holds data.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESC_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PRESC_W-1:0]            preescalar_data_rate,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          trx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          drop
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int OS_W   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [PRESC_W-1:0]    r_tick_cnt;
  logic [OS_W-1:0]       r_os_cnt;
  logic [PRESC_W-1:0]    r_p_q;
  logic                  r_trx;
  logic                  r_drop;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_empty;
  logic                  w_tick;
  logic                  w_bit_end;
  logic [PRESC_W-1:0]    w_presc_eff;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic                  w_trx_next;

  assign w_fifo_empty = (r_count == '0);
  assign tx_ready     = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_push       = tx_valid && tx_ready;
  assign w_presc_eff  = (preescalar_data_rate == '0) ? PRESC_W'(1) : preescalar_data_rate;
  assign w_tick       = (r_tick_cnt == (r_p_q - PRESC_W'(1)));
  assign w_bit_end    = w_tick && (r_os_cnt == OS_W'(OVERSAMPLE - 1));

  assign trx        = r_trx;
  assign drop       = r_drop;
  assign fifo_count = r_count;
  assign busy       = (r_state != S_IDLE) || !w_fifo_empty;

  // Storage has no reset so it can map onto distributed/block memory.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= tx_valid && !tx_ready;
    end
  end

  // Prescaler is sampled only at pop so a mid-frame change waits for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_os_cnt   <= '0;
      r_p_q      <= PRESC_W'(1);
    end else if (w_pop) begin
      r_tick_cnt <= '0;
      r_os_cnt   <= '0;
      r_p_q      <= w_presc_eff;
    end else if (r_state != S_IDLE) begin
      if (w_tick) begin
        r_tick_cnt <= '0;
        r_os_cnt   <= (r_os_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : r_os_cnt + OS_W'(1);
      end else begin
        r_tick_cnt <= r_tick_cnt + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_shift <= w_shift_next;
      if (r_state == S_START && w_bit_end) begin
        r_bit_idx <= '0;
      end else if (r_state == S_DATA && w_bit_end) begin
        r_bit_idx <= r_bit_idx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    w_shift_next = r_shift;
    if (w_pop) begin
      w_shift_next = r_mem[r_rd_ptr];
    end else if (r_state == S_DATA && w_bit_end) begin
      w_shift_next = r_shift >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end && r_bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // trx is registered from the next state so the line changes together with the state.
  always_comb begin
    w_trx_next = 1'b1;
    case (w_state_next)
      S_START: w_trx_next = 1'b0;
      S_DATA:  w_trx_next = w_shift_next[0];
      default: w_trx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_trx <= 1'b1;
    end else begin
      r_trx <= w_trx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued at push time and
// compared against frames decoded from trx with exact per-bit timing.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] presc;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        trx;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        drop;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_WIDTH(8), .OVERSAMPLE(8), .FIFO_DEPTH(4), .PRESC_W(16)
  ) dut (
    .clk(clk), .rst(rst), .preescalar_data_rate(presc),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .trx(trx), .busy(busy), .fifo_count(fifo_count), .drop(drop)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Drive one byte for one cycle; the scoreboard gets it only if the test expects acceptance.
  task automatic send(input logic [7:0] d, input bit exp_acc, output bit acc);
    tx_data  = d;
    tx_valid = 1'b1;
    acc      = tx_ready;
    if (exp_acc) sb.push_back(d);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Wait up to max_wait cycles for a start bit, then sample ten bit slots of bc cycles each.
  task automatic capture(input int bc, input int max_wait, output logic [7:0] d,
                         output logic stop_v, output int unstable, output int waits,
                         output bit timed_out);
    logic first;
    d = '0; stop_v = 1'b0; unstable = 0; waits = 0; timed_out = 1'b0; first = 1'b0;
    @(negedge clk);
    while (trx === 1'b1 && waits < max_wait) begin
      @(negedge clk);
      waits++;
    end
    if (trx !== 1'b0) begin
      timed_out = 1'b1;
      return;
    end
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < bc; j++) begin
        if (!(k == 0 && j == 0)) @(negedge clk);
        if (j == 0) first = trx;
        else if (trx !== first) unstable++;
        if (j == bc / 2) begin
          if (k >= 1 && k <= 8) d[k-1] = trx;
          if (k == 9) stop_v = trx;
        end
      end
    end
    $display("frame data=%02h bit_cycles=%0d waited=%0d", d, bc, waits);
  endtask

  task automatic test_reset;
    rst = 1'b1; presc = 16'd2; tx_data = '0; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (trx !== 1'b1) begin failures++; $display("FAIL reset_trx got=%b exp=1", trx); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (drop !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b exp=0", drop); end
  endtask

  task automatic test_single_frame;
    bit acc, to; logic [7:0] d, e; logic sv; int un, w;
    presc = 16'd2;
    send(8'hA5, 1'b1, acc);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL t1_accept got=%b exp=1", acc); end
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL t1_count got=%0d exp=1", fifo_count); end
    capture(16, 4, d, sv, un, w, to);
    checks++; if (to || w != 0) begin failures++; $display("FAIL t1_latency waited=%0d timeout=%b exp_wait=0", w, to); end
    e = sb.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL t1_data got=%02h exp=%02h", d, e); end
    checks++; if (sv !== 1'b1) begin failures++; $display("FAIL t1_stop got=%b exp=1", sv); end
    checks++; if (un != 0) begin failures++; $display("FAIL t1_bit_timing unstable=%0d exp=0", un); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy_in_stop got=%b exp=1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t1_busy_after got=%b exp=0", busy); end
    checks++; if (trx !== 1'b1) begin failures++; $display("FAIL t1_idle_line got=%b exp=1", trx); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [5];
    bit acc, to; logic [7:0] d, e; logic sv; int un, w;
    bytes[0] = 8'h01; bytes[1] = 8'h80; bytes[2] = 8'hFF; bytes[3] = 8'h00; bytes[4] = 8'h6D;
    presc = 16'd2;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          send(bytes[i], 1'b1, acc);
          checks++; if (acc !== 1'b1) begin failures++; $display("FAIL t2_accept idx=%0d got=%b exp=1", i, acc); end
        end
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL t2_count got=%0d exp=4", fifo_count); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL t2_ready_full got=%b exp=0", tx_ready); end
      end
      begin
        for (int f = 0; f < 5; f++) begin
          capture(16, (f == 0) ? 8 : 0, d, sv, un, w, to);
          checks++; if (to) begin failures++; $display("FAIL t2_contiguous frame=%0d waited=%0d exp_start", f, w); end
          else begin
            e = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
            checks++; if (d !== e) begin failures++; $display("FAIL t2_data frame=%0d got=%02h exp=%02h", f, d, e); end
            checks++; if (sv !== 1'b1 || un != 0) begin failures++; $display("FAIL t2_frame_shape frame=%0d stop=%b unstable=%0d exp=1/0", f, sv, un); end
          end
        end
      end
    join
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t2_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_overflow;
    logic [7:0] bytes [5];
    bit acc, to; logic [7:0] d, e; logic sv; int un, w;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
    presc = 16'd2;
    fork
      begin
        send(bytes[0], 1'b1, acc);
        repeat (5) @(negedge clk);
        for (int i = 1; i < 5; i++) send(bytes[i], 1'b1, acc);
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL t3_count got=%0d exp=4", fifo_count); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL t3_ready got=%b exp=0", tx_ready); end
        send(8'h3C, 1'b0, acc);
        checks++; if (acc !== 1'b0) begin failures++; $display("FAIL t3_reject got=%b exp=0", acc); end
        checks++; if (drop !== 1'b1) begin failures++; $display("FAIL t3_drop_pulse got=%b exp=1", drop); end
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL t3_count_after_drop got=%0d exp=4", fifo_count); end
        @(negedge clk);
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL t3_drop_width got=%b exp=0", drop); end
      end
      begin
        for (int f = 0; f < 5; f++) begin
          capture(16, (f == 0) ? 8 : 0, d, sv, un, w, to);
          checks++; if (to) begin failures++; $display("FAIL t3_frame_start frame=%0d waited=%0d", f, w); end
          else begin
            e = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
            checks++; if (d !== e) begin failures++; $display("FAIL t3_data frame=%0d got=%02h exp=%02h", f, d, e); end
            checks++; if (sv !== 1'b1 || un != 0) begin failures++; $display("FAIL t3_frame_shape frame=%0d stop=%b unstable=%0d exp=1/0", f, sv, un); end
          end
        end
        capture(16, 40, d, sv, un, w, to);
        checks++; if (!to) begin failures++; $display("FAIL t3_dropped_sent got=%02h exp=no_frame", d); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL t3_sb_left got=%0d exp=0", sb.size()); end
      end
    join
  endtask

  task automatic test_presc_zero;
    bit acc, to; logic [7:0] d, e; logic sv; int un, w;
    presc = 16'd0;
    send(8'h81, 1'b1, acc);
    capture(8, 4, d, sv, un, w, to);
    checks++; if (to || w != 0) begin failures++; $display("FAIL t4_latency waited=%0d timeout=%b exp_wait=0", w, to); end
    e = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
    checks++; if (d !== e) begin failures++; $display("FAIL t4_data got=%02h exp=%02h", d, e); end
    checks++; if (sv !== 1'b1 || un != 0) begin failures++; $display("FAIL t4_bit_8cyc stop=%b unstable=%0d exp=1/0", sv, un); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t4_busy_after_80 got=%b exp=0", busy); end
    presc = 16'd2;
  endtask

  task automatic test_presc_change;
    bit acc; bit to0, to1; logic [7:0] d0, d1, e; logic sv0, sv1; int un0, un1, w0, w1;
    presc = 16'd2;
    fork
      begin
        send(8'h5A, 1'b1, acc);
        send(8'hC3, 1'b1, acc);
        repeat (40) @(negedge clk);
        presc = 16'd4;
      end
      begin
        capture(16, 8, d0, sv0, un0, w0, to0);
        capture(32, 0, d1, sv1, un1, w1, to1);
      end
    join
    checks++; if (to0 || to1) begin failures++; $display("FAIL t5_frames timeout0=%b timeout1=%b exp=0/0", to0, to1); end
    e = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
    checks++; if (d0 !== e || sv0 !== 1'b1 || un0 != 0) begin failures++; $display("FAIL t5_frame0_16cyc got=%02h stop=%b unstable=%0d exp=%02h/1/0", d0, sv0, un0, e); end
    e = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
    checks++; if (d1 !== e || sv1 !== 1'b1 || un1 != 0) begin failures++; $display("FAIL t5_frame1_32cyc got=%02h stop=%b unstable=%0d exp=%02h/1/0", d1, sv1, un1, e); end
    presc = 16'd2;
  endtask

  task automatic test_reset_mid;
    bit acc, to; logic [7:0] d, e; logic sv; int un, w;
    presc = 16'd2;
    send(8'h33, 1'b1, acc);
    send(8'h44, 1'b1, acc);
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    checks++; if (trx !== 1'b1) begin failures++; $display("FAIL t6_trx got=%b exp=1", trx); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL t6_count got=%0d exp=0", fifo_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t6_busy got=%b exp=0", busy); end
    send(8'h96, 1'b1, acc);
    capture(16, 4, d, sv, un, w, to);
    checks++; if (to || w != 0) begin failures++; $display("FAIL t6_latency waited=%0d timeout=%b exp_wait=0", w, to); end
    e = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
    checks++; if (d !== e || sv !== 1'b1 || un != 0) begin failures++; $display("FAIL t6_clean_frame got=%02h stop=%b unstable=%0d exp=%02h/1/0", d, sv, un, e); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t6_busy_after got=%b exp=0", busy); end
  endtask

  initial begin
    rst = 1'b1; presc = 16'd2; tx_data = '0; tx_valid = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_presc_zero();
    test_presc_change();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
